// File: rtl/sisc_pkg.sv
// sisc_pkg: shared definitions for the SISC fetch stage.
//   PC_W_DEFAULT : default program counter / instruction address width
//   fetch_state_t: fetch FSM states
//   NOP_IR       : instruction register value after reset
package sisc_pkg;

    localparam int PC_W_DEFAULT = 16;

    localparam logic [31:0] NOP_IR = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/sisc_pc_calc.sv
// sisc_pc_calc: combinational next-PC computation.
//   i  pc       [PC_W] current program counter
//   i  br_taken        redirect instead of sequential step
//   i  br_abs          1 = absolute target, 0 = PC-relative
//   i  br_imm   [16]   branch immediate
//   o  next_pc  [PC_W] next program counter (all arithmetic mod 2^PC_W)
module sisc_pc_calc
    import sisc_pkg::*;
#(
    parameter int PC_W = PC_W_DEFAULT
) (
    input  logic [PC_W-1:0] pc,
    input  logic            br_taken,
    input  logic            br_abs,
    input  logic [15:0]     br_imm,
    output logic [PC_W-1:0] next_pc
);

    logic signed [PC_W-1:0] w_imm_sx;
    logic        [PC_W-1:0] w_imm_zx;
    logic        [PC_W-1:0] w_pc_inc;

    // Bit-wise extension so the same code truncates when PC_W < 16 and
    // extends when PC_W > 16.
    always_comb begin
        w_imm_sx = '0;
        w_imm_zx = '0;
        for (int i = 0; i < PC_W; i++) begin
            w_imm_sx[i] = (i < 16) ? br_imm[i[3:0]] : br_imm[15];
            w_imm_zx[i] = (i < 16) ? br_imm[i[3:0]] : 1'b0;
        end
    end

    assign w_pc_inc = pc + PC_W'(1);

    always_comb begin
        next_pc = w_pc_inc;
        if (br_taken) begin
            if (br_abs) next_pc = w_imm_zx;
            else        next_pc = w_pc_inc + $unsigned(w_imm_sx);
        end
    end

endmodule

// File: rtl/sisc_fetch.sv
// sisc_fetch: SISC instruction fetch stage. Owns the PC, fetches from
// instruction memory over a req/ack handshake and holds the instruction
// register until ctrl retires it.
//   i  clk, rst_f            clock / asynchronous active-high reset
//   o  im_addr [PC_W]        memory word address (= pc)
//   o  im_req                fetch request, held until im_ack
//   i  im_ack, im_data [32]  memory response
//   o  ir [32], ir_valid     instruction register and its valid flag
//   o  pc [PC_W]             address of instruction in ir / being fetched
//   i  advance               current instruction done, fetch next
//   i  br_taken, br_abs, br_imm [16]  branch redirect, sampled with advance
module sisc_fetch
    import sisc_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEFAULT,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_f,
    output logic [PC_W-1:0] im_addr,
    output logic            im_req,
    input  logic            im_ack,
    input  logic [31:0]     im_data,
    output logic [31:0]     ir,
    output logic            ir_valid,
    output logic [PC_W-1:0] pc,
    input  logic            advance,
    input  logic            br_taken,
    input  logic            br_abs,
    input  logic [15:0]     br_imm
);

    fetch_state_t    r_state;
    logic [PC_W-1:0] r_pc;
    logic [31:0]     r_ir;
    logic            r_ir_valid;
    logic            r_im_req;
    logic [PC_W-1:0] w_next_pc;

    sisc_pc_calc #(
        .PC_W (PC_W)
    ) u_pc_calc (
        .pc       (r_pc),
        .br_taken (br_taken),
        .br_abs   (br_abs),
        .br_imm   (br_imm),
        .next_pc  (w_next_pc)
    );

    // im_req is registered and set on entry to S_REQ, so it mirrors the
    // state exactly and drops asynchronously with reset.
    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            r_state    <= S_START;
            r_pc       <= RESET_PC;
            r_ir       <= NOP_IR;
            r_ir_valid <= 1'b0;
            r_im_req   <= 1'b0;
        end else begin
            case (r_state)
                S_START: begin
                    // Quiet cycle: any stray ack arriving here is dropped.
                    r_im_req <= 1'b1;
                    r_state  <= S_REQ;
                end
                S_REQ: begin
                    if (im_ack) begin
                        r_ir       <= im_data;
                        r_ir_valid <= 1'b1;
                        r_im_req   <= 1'b0;
                        r_state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (advance) begin
                        r_pc       <= w_next_pc;
                        r_ir_valid <= 1'b0;
                        r_im_req   <= 1'b1;
                        r_state    <= S_REQ;
                    end
                end
                default: begin
                    r_im_req <= 1'b0;
                    r_state  <= S_START;
                end
            endcase
        end
    end

    assign im_addr  = r_pc;
    assign im_req   = r_im_req;
    assign ir       = r_ir;
    assign ir_valid = r_ir_valid;
    assign pc       = r_pc;

endmodule

// File: tb/tb_sisc_fetch.sv
module tb_sisc_fetch;

    logic        clk = 1'b0;
    logic        rst_f;
    logic [15:0] im_addr;
    logic        im_req;
    logic        im_ack;
    logic [31:0] im_data;
    logic [31:0] ir;
    logic        ir_valid;
    logic [15:0] pc;
    logic        advance;
    logic        br_taken;
    logic        br_abs;
    logic [15:0] br_imm;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          exp_pc;
    logic [31:0] exp_ir;

    sisc_fetch dut (
        .clk      (clk),
        .rst_f    (rst_f),
        .im_addr  (im_addr),
        .im_req   (im_req),
        .im_ack   (im_ack),
        .im_data  (im_data),
        .ir       (ir),
        .ir_valid (ir_valid),
        .pc       (pc),
        .advance  (advance),
        .br_taken (br_taken),
        .br_abs   (br_abs),
        .br_imm   (br_imm)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural next-PC rule in plain integer arithmetic.
    function automatic int model_next(input int cur, input bit bt, input bit ba,
                                      input logic [15:0] imm);
        int s;
        if (!bt) return (cur + 1) & 32'hFFFF;
        if (ba)  return int'(imm);
        s = $signed(imm);
        return (cur + 1 + s) & 32'hFFFF;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after entering the request phase. Memory answers after
    // `lat` idle cycles; advance is randomly pulsed meanwhile (must be ignored).
    task automatic fetch(input int lat, input logic [31:0] data);
        for (int k = 0; k < lat; k++) begin
            chk("req_wait", {31'b0, im_req}, 32'd1);
            chk("addr_wait", {16'b0, im_addr}, exp_pc[31:0]);
            chk("irv_wait", {31'b0, ir_valid}, 32'd0);
            chk("ir_wait", ir, exp_ir);
            im_ack   = 1'b0;
            im_data  = $urandom;
            advance  = $urandom_range(0, 1);
            br_taken = 1'b1;
            br_abs   = 1'b1;
            br_imm   = $urandom;
            step();
        end
        chk("req_ack", {31'b0, im_req}, 32'd1);
        chk("addr_ack", {16'b0, im_addr}, exp_pc[31:0]);
        advance = 1'b0;
        im_ack  = 1'b1;
        im_data = data;
        step();
        im_ack  = 1'b0;
        im_data = $urandom;
        exp_ir  = data;
        chk("ir_fetched", ir, exp_ir);
        chk("irv_fetched", {31'b0, ir_valid}, 32'd1);
        chk("req_done", {31'b0, im_req}, 32'd0);
        chk("pc_fetched", {16'b0, pc}, exp_pc[31:0]);
    endtask

    // Idle in hold with spurious acks on the bus: nothing may change.
    task automatic hold(input int n);
        for (int k = 0; k < n; k++) begin
            im_ack  = $urandom_range(0, 1);
            im_data = $urandom;
            step();
            chk("ir_hold", ir, exp_ir);
            chk("irv_hold", {31'b0, ir_valid}, 32'd1);
            chk("req_hold", {31'b0, im_req}, 32'd0);
            chk("pc_hold", {16'b0, pc}, exp_pc[31:0]);
        end
        im_ack = 1'b0;
    endtask

    task automatic adv(input bit bt, input bit ba, input logic [15:0] imm);
        advance  = 1'b1;
        br_taken = bt;
        br_abs   = ba;
        br_imm   = imm;
        step();
        advance  = 1'b0;
        br_taken = 1'b0;
        br_abs   = 1'b0;
        br_imm   = $urandom;
        exp_pc   = model_next(exp_pc, bt, ba, imm);
        chk("irv_adv", {31'b0, ir_valid}, 32'd0);
        chk("req_adv", {31'b0, im_req}, 32'd1);
        chk("addr_adv", {16'b0, im_addr}, exp_pc[31:0]);
        chk("ir_adv", ir, exp_ir);
    endtask

    initial begin
        rst_f    = 1'b1;
        im_ack   = 1'b0;
        im_data  = 32'h0;
        advance  = 1'b0;
        br_taken = 1'b0;
        br_abs   = 1'b0;
        br_imm   = 16'h0;
        exp_pc   = 0;
        exp_ir   = 32'h0;
        #1;
        chk("rst_pc", {16'b0, pc}, 32'h0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_irv", {31'b0, ir_valid}, 32'd0);
        chk("rst_req", {31'b0, im_req}, 32'd0);
        step();
        step();
        rst_f = 1'b0;
        chk("start_req", {31'b0, im_req}, 32'd0);
        step();

        // Directed sequence
        fetch(2, 32'h88100001);
        adv(1'b0, 1'b0, 16'h0);
        fetch(0, 32'h11112222);
        adv(1'b1, 1'b1, 16'h0005);
        fetch(1, 32'h33334444);
        adv(1'b1, 1'b0, 16'hFFFE);
        chk("rel_back", {16'b0, im_addr}, 32'h0004);
        fetch(0, 32'h55556666);
        adv(1'b1, 1'b1, 16'h0040);
        chk("abs_40", {16'b0, im_addr}, 32'h0040);
        fetch(0, 32'h77778888);
        adv(1'b1, 1'b1, 16'hFFFF);
        fetch(0, 32'h9999AAAA);
        adv(1'b0, 1'b0, 16'h0);
        chk("wrap", {16'b0, im_addr}, 32'h0000);
        fetch(2, 32'hBBBBCCCC);
        adv(1'b1, 1'b1, 16'h0010);
        fetch(0, 32'hDDDDEEEE);
        adv(1'b1, 1'b0, 16'h7FFF);
        chk("rel_fwd", {16'b0, im_addr}, 32'h8010);
        fetch(3, 32'hCAFEF00D);
        hold(3);

        // Randomized instruction stream
        for (int t = 0; t < 200; t++) begin
            adv(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
            fetch($urandom_range(0, 3), $urandom);
            hold($urandom_range(0, 3));
        end

        // Reset in the middle of a pending request
        adv(1'b1, 1'b1, 16'h0020);
        step();
        chk("pend_addr", {16'b0, im_addr}, 32'h0020);
        chk("pend_req", {31'b0, im_req}, 32'd1);
        #3;
        rst_f = 1'b1;
        #1;
        chk("arst_req", {31'b0, im_req}, 32'd0);
        chk("arst_pc", {16'b0, pc}, 32'h0);
        chk("arst_ir", ir, 32'h0);
        chk("arst_irv", {31'b0, ir_valid}, 32'd0);
        step();
        rst_f   = 1'b0;
        exp_pc  = 0;
        exp_ir  = 32'h0;
        im_ack  = 1'b1;
        im_data = 32'hDEADBEEF;
        step();
        im_ack  = 1'b0;
        chk("late_ack_ir", ir, 32'h0);
        chk("late_ack_irv", {31'b0, ir_valid}, 32'd0);
        fetch(1, 32'h12345678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
